// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
//
// Multi-channel clock-enable generator running on a DCM output clock.
// A lock-qualification sequencer (RESET -> WAIT_LOCK -> SETTLE -> RUN) keeps
// every channel output at 0 until the upstream DCM lock has been stable for
// LOCK_WAIT cycles. In RUN each channel produces a divided clock level and a
// one-cycle strobe with programmable ratio and phase. SYNC re-aligns all
// channels at run time.
//
// Ports
//   BUS_CLK    in   block clock
//   BUS_RST    in   synchronous, active-high reset
//   LOCKED_IN  in   DCM LOCKED, asynchronous (double-flop synchronised here)
//   DIV        in   per-channel divide ratio, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   PHASE      in   per-channel phase offset in cycles, same packing as DIV
//   EN         in   per-channel enable
//   SYNC       in   one-cycle re-align pulse (acts one edge after it is sampled)
//   CLK_OUT    out  registered divided clock level per channel
//   STB        out  registered one-cycle strobe at each CLK_OUT period start
//   READY      out  high while the sequencer is in RUN
// ---------------------------------------------------------------------------
module clk_div_bank #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8,
    parameter int LOCK_WAIT = 16
) (
    input  logic                          BUS_CLK,
    input  logic                          BUS_RST,
    input  logic                          LOCKED_IN,
    input  logic [CHANNELS*CNT_WIDTH-1:0] DIV,
    input  logic [CHANNELS*CNT_WIDTH-1:0] PHASE,
    input  logic [CHANNELS-1:0]           EN,
    input  logic                          SYNC,
    output logic [CHANNELS-1:0]           CLK_OUT,
    output logic [CHANNELS-1:0]           STB,
    output logic                          READY
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN
    } state_t;

    localparam int                    SETTLE_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(LOCK_WAIT - 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]    HALF_ONE    = (CNT_WIDTH + 1)'(1);

    // -----------------------------------------------------------------------
    // Lock synchroniser and sequencer
    // -----------------------------------------------------------------------
    logic                lock_meta_q, lock_meta_d;
    logic                lock_s_q,    lock_s_d;
    state_t              state_q,     state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                sync_q,      sync_d;

    // Channel control shared by all channels.
    logic stay_run;   // in RUN now and still in RUN after this edge
    logic align_all;  // every channel reloads its align value on this edge

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        lock_meta_d  = LOCKED_IN;
        lock_s_d     = lock_meta_q;
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // Loss of lock leaves RUN on this edge, so it also suppresses any
        // pending or new SYNC.
        stay_run  = (state_q == ST_RUN) && lock_s_q;
        align_all = ((state_q == ST_SETTLE) && (state_d == ST_RUN)) || (stay_run && sync_q);
        sync_d    = SYNC && stay_run;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= ST_RESET;
            settle_cnt_q <= '0;
            sync_q       <= 1'b0;
        end else begin
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            sync_q       <= sync_d;
        end
    end

    assign READY = (state_q == ST_RUN);

    // -----------------------------------------------------------------------
    // Divider channels
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_WIDTH-1:0] div_i;
        logic [CNT_WIDTH-1:0] phase_i;
        logic [CNT_WIDTH-1:0] align_val;
        logic [CNT_WIDTH:0]   half_ns;
        logic                 wrap;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [CNT_WIDTH-1:0] ns_q,  ns_d;
        logic                 clk_out_q, clk_out_d;
        logic                 stb_q,     stb_d;

        assign div_i   = DIV[g*CNT_WIDTH +: CNT_WIDTH];
        assign phase_i = PHASE[g*CNT_WIDTH +: CNT_WIDTH];

        // Starting at N-p puts the first zero p cycles after the align edge;
        // a phase of 0 or one not smaller than N behaves as phase 0.
        assign align_val = ((phase_i == '0) || (phase_i >= div_i)) ? '0 : (div_i - phase_i);

        // High phase is ceil(Ns/2); one extra bit keeps Ns+1 from overflowing.
        assign half_ns = ({1'b0, ns_q} + HALF_ONE) >> 1;

        // Ns of 0 or 1 wraps every cycle, which also lets a disabled (Ns=0)
        // channel pick up a new nonzero DIV without waiting for a SYNC.
        assign wrap = (ns_q <= CNT_ONE) || (cnt_q == (ns_q - CNT_ONE));

        always_comb begin
            cnt_d     = cnt_q;
            ns_d      = ns_q;
            clk_out_d = 1'b0;
            stb_d     = 1'b0;

            // A disabled channel sits at its align value so that channels
            // re-enabled on the same edge start out mutually aligned.
            if (align_all || (stay_run && !EN[g])) begin
                ns_d  = div_i;
                cnt_d = align_val;
            end else if (stay_run) begin
                if (wrap) begin
                    // Ratio changes only take effect at a period boundary.
                    cnt_d = '0;
                    ns_d  = div_i;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            if (stay_run && EN[g] && (ns_q != '0)) begin
                stb_d     = (cnt_q == '0);
                clk_out_d = ({1'b0, cnt_q} < half_ns);
            end
        end

        always_ff @(posedge BUS_CLK) begin
            if (BUS_RST) begin
                cnt_q     <= '0;
                ns_q      <= '0;
                clk_out_q <= 1'b0;
                stb_q     <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                ns_q      <= ns_d;
                clk_out_q <= clk_out_d;
                stb_q     <= stb_d;
            end
        end

        assign CLK_OUT[g] = clk_out_q;
        assign STB[g]     = stb_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// ---------------------------------------------------------------------------
// tb_clk_div_bank
//
// Self-checking bench for clk_div_bank (CHANNELS=4, CNT_WIDTH=8,
// LOCK_WAIT=16). Drives inputs one time unit after the rising edge and
// samples outputs at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_clk_div_bank;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int LW = 16;

    logic            BUS_CLK = 1'b0;
    logic            BUS_RST;
    logic            LOCKED_IN;
    logic [CH*W-1:0] DIV;
    logic [CH*W-1:0] PHASE;
    logic [CH-1:0]   EN;
    logic            SYNC;
    logic [CH-1:0]   CLK_OUT;
    logic [CH-1:0]   STB;
    logic            READY;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CH-1:0] en;
        logic          sync;
        logic [CH-1:0] exp_stb;
        logic [CH-1:0] exp_clk;
    } vec_t;

    vec_t vecs [10];

    always #5 BUS_CLK = ~BUS_CLK;

    clk_div_bank #(
        .CHANNELS  (CH),
        .CNT_WIDTH (W),
        .LOCK_WAIT (LW)
    ) dut (
        .BUS_CLK   (BUS_CLK),
        .BUS_RST   (BUS_RST),
        .LOCKED_IN (LOCKED_IN),
        .DIV       (DIV),
        .PHASE     (PHASE),
        .EN        (EN),
        .SYNC      (SYNC),
        .CLK_OUT   (CLK_OUT),
        .STB       (STB),
        .READY     (READY)
    );

    task automatic step();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Steps until READY is high; n is the number of edges taken (60 = gave up).
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 60) begin
            step();
            n++;
            if (READY === 1'b1) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Outputs after edges A+1..A+10 for DIV={4,5,5,4}, PHASE={0,0,2,0}.
        // Bit order is {ch3, ch2, ch1, ch0}.
        vecs[0] = '{4'hf, 1'b0, 4'b1101, 4'b1101};
        vecs[1] = '{4'hf, 1'b0, 4'b0000, 4'b1101};
        vecs[2] = '{4'hf, 1'b0, 4'b0010, 4'b0110};
        vecs[3] = '{4'hf, 1'b0, 4'b0000, 4'b0010};
        vecs[4] = '{4'hf, 1'b0, 4'b1001, 4'b1011};
        vecs[5] = '{4'hf, 1'b0, 4'b0100, 4'b1101};
        vecs[6] = '{4'hf, 1'b0, 4'b0000, 4'b0100};
        vecs[7] = '{4'hf, 1'b0, 4'b0010, 4'b0110};
        vecs[8] = '{4'hf, 1'b0, 4'b1001, 4'b1011};
        vecs[9] = '{4'hf, 1'b0, 4'b0000, 4'b1011};

        BUS_RST   = 1'b1;
        LOCKED_IN = 1'b0;
        SYNC      = 1'b0;
        EN        = 4'hf;
        DIV       = {8'd4, 8'd5, 8'd5, 8'd4};
        PHASE     = {8'd0, 8'd0, 8'd2, 8'd0};

        // ---- reset state ----
        repeat (3) step();
        check("reset_ready",   32'(READY),   32'd0);
        check("reset_clk_out", 32'(CLK_OUT), 32'd0);
        check("reset_stb",     32'(STB),     32'd0);

        BUS_RST = 1'b0;
        repeat (2) step();
        check("unlocked_ready", 32'(READY), 32'd0);

        // ---- lock qualification: READY on the 19th edge sampling lock ----
        LOCKED_IN = 1'b1;
        wait_ready(n);
        check("lock_latency", n, 19);
        check("align_edge_stb", 32'(STB),     32'd0);
        check("align_edge_clk", 32'(CLK_OUT), 32'd0);

        // ---- table: ratio/phase/odd duty after RUN entry ----
        for (int i = 0; i < 10; i++) begin
            EN   = vecs[i].en;
            SYNC = vecs[i].sync;
            step();
            check($sformatf("vec%0d_stb", i),   32'(STB),     32'(vecs[i].exp_stb));
            check($sformatf("vec%0d_clk", i),   32'(CLK_OUT), 32'(vecs[i].exp_clk));
            check($sformatf("vec%0d_ready", i), 32'(READY),   32'd1);
        end
        SYNC = 1'b0;

        // ---- SYNC with PHASE1=7 (>= N, acts as phase 0) ----
        PHASE = {8'd0, 8'd0, 8'd7, 8'd0};
        SYNC  = 1'b1;
        step();                 // edge S samples SYNC
        SYNC  = 1'b0;
        step();                 // S+1: align
        step();                 // S+2: first strobe of every phase-0 channel
        check("sync_stb_t1", 32'(STB),     32'(4'b1111));
        check("sync_clk_t1", 32'(CLK_OUT), 32'(4'b1111));
        repeat (4) step();
        check("sync_stb_t5", 32'(STB),     32'(4'b1001));
        check("sync_clk_t5", 32'(CLK_OUT), 32'(4'b1001));
        step();
        check("sync_stb_t6", 32'(STB),     32'(4'b0110));
        check("sync_clk_t6", 32'(CLK_OUT), 32'(4'b1111));

        // ---- ratio change 4 -> 8 with ch0 at count 1 ----
        DIV = {8'd4, 8'd5, 8'd5, 8'd8};
        for (int t = 7; t <= 26; t++) begin
            int k;
            int c;
            int ns;
            k = t - 1;
            if (k < 8) begin
                c  = k % 4;
                ns = 4;
            end else begin
                c  = (k - 8) % 8;
                ns = 8;
            end
            step();
            check($sformatf("ratio_t%0d_stb0", t), 32'(STB[0]),     (c == 0) ? 1 : 0);
            check($sformatf("ratio_t%0d_clk0", t), 32'(CLK_OUT[0]), (c < (ns + 1) / 2) ? 1 : 0);
        end

        // ---- EN drop on ch0 and ch3, SYNC while disabled, re-enable ----
        DIV = {8'd4, 8'd5, 8'd5, 8'd4};
        EN  = 4'b0110;
        for (int d = 0; d < 5; d++) begin
            SYNC = (d == 1);
            step();
            check($sformatf("en_off_d%0d", d), 32'({STB[3], STB[0], CLK_OUT[3], CLK_OUT[0]}), 32'd0);
        end
        SYNC = 1'b0;
        EN   = 4'hf;
        for (int j = 0; j < 9; j++) begin
            step();
            check($sformatf("en_on_j%0d_stb", j), 32'({STB[3], STB[0]}),
                  (j % 4 == 0) ? 32'd3 : 32'd0);
            check($sformatf("en_on_j%0d_clk", j), 32'({CLK_OUT[3], CLK_OUT[0]}),
                  (j % 4 < 2) ? 32'd3 : 32'd0);
        end

        // ---- special ratios: ch2 DIV=0 (off), ch3 DIV=1 (always on) ----
        DIV  = {8'd1, 8'd0, 8'd5, 8'd4};
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        step();
        for (int j = 0; j < 6; j++) begin
            step();
            check($sformatf("div01_j%0d_stb", j), 32'(STB[3:2]),     32'(2'b10));
            check($sformatf("div01_j%0d_clk", j), 32'(CLK_OUT[3:2]), 32'(2'b10));
        end

        // ---- loss of lock in RUN: outputs forced 0 on the 3rd edge ----
        LOCKED_IN = 1'b0;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (READY !== 1'b1) break;
        end
        check("unlock_latency",  n,             3);
        check("unlock_stb",      32'(STB),     32'd0);
        check("unlock_clk",      32'(CLK_OUT), 32'd0);
        step();
        check("unlock_hold_clk", 32'(CLK_OUT), 32'd0);

        // ---- lock glitch: 10 high, 1 low, then full settle again ----
        LOCKED_IN = 1'b1;
        repeat (10) step();
        check("glitch_pre_ready", 32'(READY), 32'd0);
        LOCKED_IN = 1'b0;
        step();
        LOCKED_IN = 1'b1;
        wait_ready(n);
        check("glitch_relock_latency", n, 19);
        step();
        check("relock_first_stb", 32'(STB),     32'(4'b1011));
        check("relock_first_clk", 32'(CLK_OUT), 32'(4'b1011));

        // ---- BUS_RST in RUN ----
        BUS_RST = 1'b1;
        step();
        check("midrst_ready", 32'(READY),   32'd0);
        check("midrst_stb",   32'(STB),     32'd0);
        check("midrst_clk",   32'(CLK_OUT), 32'd0);
        BUS_RST = 1'b0;
        step();
        check("post_rst_ready", 32'(READY), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
